// File: rtl/arbiter_requester.sv
// Requester-side front end for a round-robin arbiter: per-client pending counts,
// request vector, grant consumption, issue quota, grant statistics and done flag.

module arbiter_requester_client #(
    parameter int PENDING_WIDTH = 2,
    parameter int QUOTA         = 64,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_grant_hit,
    output logic                   o_request,
    output logic                   o_push_ready,
    output logic                   o_granted,
    output logic                   o_client_done,
    output logic [COUNT_WIDTH-1:0] o_grant_count
);
    localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0]   QUOTA_C  = COUNT_WIDTH'(QUOTA);

    logic [PENDING_WIDTH-1:0] pend;
    logic [COUNT_WIDTH-1:0]   issued;
    logic [COUNT_WIDTH-1:0]   gcnt;
    logic                     push_acc;
    logic                     grant_acc;

    // Request and ready are pure decodes of registered state.
    assign o_request     = (pend != '0);
    assign o_push_ready  = (pend != PEND_MAX) && (issued < QUOTA_C);
    assign push_acc      = i_push && o_push_ready;
    assign grant_acc     = o_request && i_grant_hit;
    assign o_client_done = (issued == QUOTA_C) && (pend == '0);
    assign o_grant_count = gcnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend      <= '0;
            issued    <= '0;
            gcnt      <= '0;
            o_granted <= 1'b0;
        end else begin
            // Push and grant in the same cycle cancel out.
            if (push_acc && !grant_acc)
                pend <= pend + PENDING_WIDTH'(1);
            else if (grant_acc && !push_acc)
                pend <= pend - PENDING_WIDTH'(1);
            if (push_acc && (issued != '1))
                issued <= issued + COUNT_WIDTH'(1);
            if (grant_acc && (gcnt != '1))
                gcnt <= gcnt + COUNT_WIDTH'(1);
            o_granted <= grant_acc;
        end
    end
endmodule

module arbiter_requester #(
    parameter int REQUEST_WIDTH = 8,
    parameter int PENDING_WIDTH = 2,
    parameter int QUOTA         = 64,
    parameter int COUNT_WIDTH   = 16,
    parameter int GRANT_WIDTH   = (REQUEST_WIDTH > 1) ? $clog2(REQUEST_WIDTH) : 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [REQUEST_WIDTH-1:0]           i_push,
    output logic [REQUEST_WIDTH-1:0]           o_push_ready,
    output logic [REQUEST_WIDTH-1:0]           o_request,
    input  logic [GRANT_WIDTH-1:0]             i_grant,
    output logic [REQUEST_WIDTH-1:0]           o_granted,
    output logic [REQUEST_WIDTH*COUNT_WIDTH-1:0] o_grant_count,
    output logic [COUNT_WIDTH-1:0]             o_busy_cycles,
    output logic                               o_done
);
    logic [REQUEST_WIDTH-1:0]                  grant_hit;
    logic [REQUEST_WIDTH-1:0]                  client_done;
    logic [REQUEST_WIDTH-1:0][COUNT_WIDTH-1:0] gcnt;

    // Out-of-range grant indices simply match no client.
    for (genvar i = 0; i < REQUEST_WIDTH; i++) begin : g_client
        assign grant_hit[i] = (i_grant == GRANT_WIDTH'(i));
        assign o_grant_count[i*COUNT_WIDTH +: COUNT_WIDTH] = gcnt[i];

        arbiter_requester_client #(
            .PENDING_WIDTH (PENDING_WIDTH),
            .QUOTA         (QUOTA),
            .COUNT_WIDTH   (COUNT_WIDTH)
        ) u_client (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_push        (i_push[i]),
            .i_grant_hit   (grant_hit[i]),
            .o_request     (o_request[i]),
            .o_push_ready  (o_push_ready[i]),
            .o_granted     (o_granted[i]),
            .o_client_done (client_done[i]),
            .o_grant_count (gcnt[i])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busy_cycles <= '0;
            o_done        <= 1'b0;
        end else begin
            if ((o_request != '0) && (o_busy_cycles != '1))
                o_busy_cycles <= o_busy_cycles + COUNT_WIDTH'(1);
            // Sticky until reset: once all quotas drain the run is over.
            if (&client_done)
                o_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_arbiter_requester.sv
// Directed bench for arbiter_requester with a behavioural round-robin arbiter
// driving i_grant during the quota run.

module tb_arbiter_requester;
    localparam int RW = 8;
    localparam int CW = 16;
    localparam int GW = 3;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [RW-1:0]   i_push;
    logic [RW-1:0]   o_push_ready;
    logic [RW-1:0]   o_request;
    logic [GW-1:0]   i_grant;
    logic [RW-1:0]   o_granted;
    logic [RW*CW-1:0] o_grant_count;
    logic [CW-1:0]   o_busy_cycles;
    logic            o_done;

    logic [GW-1:0]   man_grant;
    logic [GW-1:0]   rr_grant;
    logic [GW-1:0]   rr_ptr;
    logic            rr_en;
    int              nvec = 0;
    int              nerr = 0;
    int              wait_cnt [RW];
    int              max_wait;

    arbiter_requester #(
        .REQUEST_WIDTH (RW),
        .PENDING_WIDTH (2),
        .QUOTA         (64),
        .COUNT_WIDTH   (CW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_push        (i_push),
        .o_push_ready  (o_push_ready),
        .o_request     (o_request),
        .i_grant       (i_grant),
        .o_granted     (o_granted),
        .o_grant_count (o_grant_count),
        .o_busy_cycles (o_busy_cycles),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Round-robin reference arbiter: search starts one past the last grant.
    always_comb begin
        int idx;
        logic found;
        rr_grant = '0;
        found    = 1'b0;
        for (int k = 1; k <= RW; k++) begin
            idx = (int'(rr_ptr) + k) % RW;
            if (!found && o_request[idx]) begin
                rr_grant = idx[GW-1:0];
                found    = 1'b1;
            end
        end
    end

    assign i_grant = rr_en ? rr_grant : man_grant;

    always @(posedge i_clk) begin
        if (i_rst)
            rr_ptr <= GW'(RW - 1);
        else if (rr_en && (o_request != '0))
            rr_ptr <= rr_grant;
        for (int i = 0; i < RW; i++) begin
            if (rr_en && o_request[i] && (int'(i_grant) != i))
                wait_cnt[i] = wait_cnt[i] + 1;
            else
                wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait)
                max_wait = wait_cnt[i];
        end
    end

    function automatic logic [CW-1:0] gcnt(input int i);
        return o_grant_count[i*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_push = '0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if (o_request !== 8'h00) begin nerr++; $display("FAIL reset_request got %h want 00", o_request); end
        nvec++;
        if (o_push_ready !== 8'hFF) begin nerr++; $display("FAIL reset_push_ready got %h want ff", o_push_ready); end
        nvec++;
        if ((o_busy_cycles !== 16'd0) || (o_done !== 1'b0) || (o_granted !== 8'h00))
        begin nerr++; $display("FAIL reset_stats busy=%0d done=%b granted=%h want 0/0/00", o_busy_cycles, o_done, o_granted); end
        // Build pend[3]=2 plus a grant on client 1, then reset mid-traffic.
        man_grant = 3'd7;
        i_push = 8'h0A;
        tick();
        i_push = 8'h08;
        tick();
        i_push = '0;
        man_grant = 3'd1;
        tick();
        man_grant = 3'd7;
        nvec++;
        if ((o_request !== 8'h08) || (gcnt(1) !== 16'd1))
        begin nerr++; $display("FAIL reset_pre_traffic req=%h gcnt1=%0d want 08/1", o_request, gcnt(1)); end
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        nvec++;
        if ((o_request !== 8'h00) || (o_push_ready !== 8'hFF))
        begin nerr++; $display("FAIL reset_mid req=%h ready=%h want 00/ff", o_request, o_push_ready); end
        nvec++;
        if ((gcnt(1) !== 16'd0) || (o_busy_cycles !== 16'd0) || (o_granted !== 8'h00))
        begin nerr++; $display("FAIL reset_mid_counts gcnt1=%0d busy=%0d granted=%h want 0/0/00", gcnt(1), o_busy_cycles, o_granted); end
        tick();
        nvec++;
        if ((o_request !== 8'h00) || (o_granted !== 8'h00))
        begin nerr++; $display("FAIL reset_no_stale req=%h granted=%h want 00/00", o_request, o_granted); end
    endtask

    task automatic test_single();
        do_reset();
        man_grant = 3'd0;
        i_push = 8'h20;
        tick();
        i_push = '0;
        nvec++;
        if (o_request !== 8'h20) begin nerr++; $display("FAIL single_req got %h want 20", o_request); end
        man_grant = 3'd5;
        tick();
        man_grant = 3'd0;
        nvec++;
        if ((o_request !== 8'h00) || (o_granted !== 8'h20))
        begin nerr++; $display("FAIL single_grant req=%h granted=%h want 00/20", o_request, o_granted); end
        nvec++;
        if ((gcnt(5) !== 16'd1) || (o_busy_cycles !== 16'd1))
        begin nerr++; $display("FAIL single_counts gcnt5=%0d busy=%0d want 1/1", gcnt(5), o_busy_cycles); end
        tick();
        nvec++;
        if (o_granted !== 8'h00) begin nerr++; $display("FAIL single_pulse got %h want 00", o_granted); end
    endtask

    task automatic test_full();
        do_reset();
        man_grant = 3'd7;
        i_push = 8'h01;
        tick();
        tick();
        tick();
        nvec++;
        if (o_push_ready !== 8'hFE) begin nerr++; $display("FAIL full_ready got %h want fe", o_push_ready); end
        tick();
        i_push = '0;
        // Three grants drain pend[0]; a fourth must find nothing.
        man_grant = 3'd0;
        tick();
        tick();
        nvec++;
        if ((o_request !== 8'h01) || (gcnt(0) !== 16'd2))
        begin nerr++; $display("FAIL full_drain2 req=%h gcnt0=%0d want 01/2", o_request, gcnt(0)); end
        tick();
        nvec++;
        if ((o_request !== 8'h00) || (gcnt(0) !== 16'd3) || (o_granted !== 8'h01))
        begin nerr++; $display("FAIL full_drain3 req=%h gcnt0=%0d granted=%h want 00/3/01", o_request, gcnt(0), o_granted); end
        tick();
        nvec++;
        if ((gcnt(0) !== 16'd3) || (o_granted !== 8'h00))
        begin nerr++; $display("FAIL full_dropped gcnt0=%0d granted=%h want 3/00", gcnt(0), o_granted); end
        man_grant = 3'd7;
    endtask

    task automatic test_push_and_grant();
        do_reset();
        man_grant = 3'd7;
        i_push = 8'h04;
        tick();
        man_grant = 3'd2;
        tick();
        i_push = '0;
        nvec++;
        if ((o_request !== 8'h04) || (gcnt(2) !== 16'd1) || (o_granted !== 8'h04))
        begin nerr++; $display("FAIL pushgrant req=%h gcnt2=%0d granted=%h want 04/1/04", o_request, gcnt(2), o_granted); end
        tick();
        man_grant = 3'd7;
        nvec++;
        if ((o_request !== 8'h00) || (gcnt(2) !== 16'd2) || (o_push_ready !== 8'hFF))
        begin nerr++; $display("FAIL pushgrant_drain req=%h gcnt2=%0d ready=%h want 00/2/ff", o_request, gcnt(2), o_push_ready); end
    endtask

    task automatic test_stray_grant();
        do_reset();
        man_grant = 3'd7;
        i_push = 8'h01;
        tick();
        i_push = '0;
        man_grant = 3'd4;
        tick();
        tick();
        man_grant = 3'd7;
        nvec++;
        if ((o_request !== 8'h01) || (o_granted !== 8'h00))
        begin nerr++; $display("FAIL stray req=%h granted=%h want 01/00", o_request, o_granted); end
        nvec++;
        if ((gcnt(0) !== 16'd0) || (gcnt(4) !== 16'd0) || (o_busy_cycles !== 16'd2))
        begin nerr++; $display("FAIL stray_counts gcnt0=%0d gcnt4=%0d busy=%0d want 0/0/2", gcnt(0), gcnt(4), o_busy_cycles); end
    endtask

    task automatic test_quota();
        int cyc;
        int sum;
        do_reset();
        max_wait = 0;
        rr_en = 1'b1;
        cyc = 0;
        while (!o_done && (cyc < 20000)) begin
            i_push = RW'($urandom);
            tick();
            cyc++;
        end
        i_push = '0;
        nvec++;
        if (o_done !== 1'b1) begin nerr++; $display("FAIL quota_done got %b want 1 after %0d cycles", o_done, cyc); end
        sum = 0;
        for (int i = 0; i < RW; i++) begin
            sum += int'(gcnt(i));
            nvec++;
            if (gcnt(i) !== 16'd64) begin nerr++; $display("FAIL quota_gcnt%0d got %0d want 64", i, gcnt(i)); end
        end
        nvec++;
        if (sum != 512) begin nerr++; $display("FAIL quota_sum got %0d want 512", sum); end
        nvec++;
        if (max_wait > RW - 1) begin nerr++; $display("FAIL quota_starve max_wait=%0d want <=%0d", max_wait, RW - 1); end
        // Quota exhausted: pushes are refused and done is sticky.
        i_push = 8'hFF;
        tick();
        tick();
        i_push = '0;
        nvec++;
        if ((o_push_ready !== 8'h00) || (o_request !== 8'h00) || (o_done !== 1'b1))
        begin nerr++; $display("FAIL quota_closed ready=%h req=%h done=%b want 00/00/1", o_push_ready, o_request, o_done); end
        rr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < RW; i++) wait_cnt[i] = 0;
        max_wait  = 0;
        rr_en     = 1'b0;
        man_grant = 3'd7;
        i_push    = '0;
        i_rst     = 1'b1;
        test_reset();
        test_single();
        test_full();
        test_push_and_grant();
        test_stray_grant();
        test_quota();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
